// File: rtl/sar_pkg.sv
// Shared definitions for the SAR controller: state encoding and the
// sizing helper for the sample-phase counter.
package sar_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAMPLE  = 2'd1,
        ST_CONVERT = 2'd2
    } sar_state_e;

    // Bits needed to hold a down-counter starting at n-1 (minimum 1 bit).
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/sar_ctrl_param_if.sv
// Signal bundle between the SAR controller (master) and the analog
// front end / result consumer (slave).
interface sar_ctrl_param_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             cont;
    logic             cmp;
    logic             sample;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic [WIDTH-1:0] result;
    logic             result_valid;
    logic             result_ready;
    logic             overrun;
    logic             ovr_clr;

    modport master (
        input  start, cont, cmp, result_ready, ovr_clr,
        output sample, dac_code, busy, result, result_valid, overrun
    );

    modport slave (
        output start, cont, cmp, result_ready, ovr_clr,
        input  sample, dac_code, busy, result, result_valid, overrun
    );
endinterface

// File: rtl/sar_code_reg.sv
// Successive-approximation register: holds the decided bits plus the
// one-hot pointer of the bit currently on trial. The code returns to zero
// after the last trial so the DAC idles at code 0.
module sar_code_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load_msb_i,
    input  logic             step_i,
    input  logic             decision_i,
    output logic [WIDTH-1:0] code_o,
    output logic             last_bit_o
);
    localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;

    // Next trial: resolve the current bit, then raise the next lower one.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        code_d = decision_i ? code_q : (code_q & ~ptr_q);
        ptr_d  = ptr_q >> 1;
        if (ptr_q[0]) begin
            code_d = '0;
        end else begin
            code_d = code_d | ptr_d;
        end
    end

    // Approximation register and bit pointer.
    always_ff @(posedge clock) begin
        // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            code_q <= '0;
            ptr_q  <= '0;
        end else if (load_msb_i) begin
            code_q <= MSB_ONLY;
            ptr_q  <= MSB_ONLY;
        end else if (step_i) begin
            code_q <= code_d;
            ptr_q  <= ptr_d;
        end
    end

    assign code_o     = code_q;
    assign last_bit_o = ptr_q[0];

endmodule

// File: rtl/sar_ctrl_param.sv
// SAR ADC controller: sample phase, MSB-first binary search, result
// delivery over valid/ready with sticky overrun flag.
module sar_ctrl_param
    import sar_pkg::*;
#(
    parameter int WIDTH         = 4,
    parameter int SAMPLE_CYCLES = 1,
    parameter bit CMP_POL       = 1'b1
) (
    input logic              clock,
    input logic              rst_n,
    sar_ctrl_param_if.master bus
);
    localparam int               CW       = cnt_width(SAMPLE_CYCLES);
    localparam logic [CW-1:0]    CNT_INIT = CW'(SAMPLE_CYCLES - 1);

    sar_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic             sample_q;
    logic             busy_q;
    logic [WIDTH-1:0] result_q;
    logic             valid_q;
    logic             overrun_q;

    logic [WIDTH-1:0] code_w;
    logic             last_bit_w;
    logic             load_msb;
    logic             step;
    logic             decision;
    logic [WIDTH-1:0] result_d;

    // The first trial is loaded on the edge that leaves SAMPLE.
    assign load_msb = (state_q == ST_SAMPLE) && (cnt_q == '0);
    assign step     = (state_q == ST_CONVERT);
    assign decision = (bus.cmp == CMP_POL);
    // On the last trial the pointer sits on bit 0, so the final code is the
    // upper decided bits plus this cycle's decision.
    assign result_d = {code_w[WIDTH-1:1], decision};

    sar_code_reg #(
        .WIDTH (WIDTH)
    ) u_code_reg (
        .clock      (clock),
        .rst_n      (rst_n),
        .load_msb_i (load_msb),
        .step_i     (step),
        .decision_i (decision),
        .code_o     (code_w),
        .last_bit_o (last_bit_w)
    );

    // Control FSM with registered outputs, result buffer and overrun flag.
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sample_q  <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            // Consumer handshake and flag clear; a completion later in this
            // block overrides both, giving set priority over clear.
            if (valid_q && bus.result_ready) begin
                valid_q <= 1'b0;
            end
            if (bus.ovr_clr) begin
                overrun_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q  <= ST_SAMPLE;
                        cnt_q    <= CNT_INIT;
                        sample_q <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (cnt_q == '0) begin
                        state_q  <= ST_CONVERT;
                        sample_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_CONVERT: begin
                    if (last_bit_w) begin
                        result_q <= result_d;
                        valid_q  <= 1'b1;
                        if (valid_q && !bus.result_ready) begin
                            overrun_q <= 1'b1;
                        end
                        if (bus.cont) begin
                            state_q  <= ST_SAMPLE;
                            cnt_q    <= CNT_INIT;
                            sample_q <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    sample_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sample       = sample_q;
    assign bus.dac_code     = code_w;
    assign bus.busy         = busy_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
    assign bus.overrun      = overrun_q;

endmodule

// File: tb/tb_sar_ctrl_param.sv
// Directed bench for sar_ctrl_param: a 4-bit instance with a true
// comparator model and an 8-bit instance with an inverted comparator.
module tb_sar_ctrl_param;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] vin4 = '0;
    logic [7:0] vin8 = '0;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    sar_ctrl_param_if #(.WIDTH(4)) b4 ();
    sar_ctrl_param_if #(.WIDTH(8)) b8 ();

    // Comparator models: true polarity for the 4-bit DUT, inverted for the 8-bit DUT.
    assign b4.cmp = (vin4 >= b4.dac_code);
    assign b8.cmp = !(vin8 >= b8.dac_code);

    sar_ctrl_param #(
        .WIDTH (4), .SAMPLE_CYCLES (1), .CMP_POL (1'b1)
    ) dut4 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (b4)
    );

    sar_ctrl_param #(
        .WIDTH (8), .SAMPLE_CYCLES (3), .CMP_POL (1'b0)
    ) dut8 (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (b8)
    );

    typedef struct packed {
        logic [3:0]  vin;
        logic [15:0] dacs;   // four expected trial codes, first in the top nibble
        logic [3:0]  res;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Advance one rising edge and settle past it before sampling.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    // Single-shot conversion of one vector, then consume the result.
    task automatic run_vec(input vec_t v);
        vin4     = v.vin;
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        check("sample_hi", 32'(b4.sample), 32'd1);
        check("busy_hi", 32'(b4.busy), 32'd1);
        check("sample_dac0", 32'(b4.dac_code), 32'd0);
        for (int k = 0; k < 4; k++) begin
            tick();
            check("trial_dac", 32'(b4.dac_code), 32'(v.dacs[15-4*k -: 4]));
            check("valid_lo", 32'(b4.result_valid), 32'd0);
        end
        tick();
        check("result", 32'(b4.result), 32'(v.res));
        check("valid_hi", 32'(b4.result_valid), 32'd1);
        check("done_dac0", 32'(b4.dac_code), 32'd0);
        check("done_busy0", 32'(b4.busy), 32'd0);
        b4.result_ready = 1'b1;
        tick();
        check("valid_fall", 32'(b4.result_valid), 32'd0);
        check("no_overrun", 32'(b4.overrun), 32'd0);
        b4.result_ready = 1'b0;
    endtask

    initial begin
        vecs[0] = '{vin: 4'd11, dacs: {4'd8, 4'd12, 4'd10, 4'd11}, res: 4'd11};
        vecs[1] = '{vin: 4'd0,  dacs: {4'd8, 4'd4,  4'd2,  4'd1},  res: 4'd0};
        vecs[2] = '{vin: 4'd15, dacs: {4'd8, 4'd12, 4'd14, 4'd15}, res: 4'd15};
        vecs[3] = '{vin: 4'd5,  dacs: {4'd8, 4'd4,  4'd6,  4'd5},  res: 4'd5};
        vecs[4] = '{vin: 4'd8,  dacs: {4'd8, 4'd12, 4'd10, 4'd9},  res: 4'd8};

        b4.start = 1'b0; b4.cont = 1'b0; b4.result_ready = 1'b0; b4.ovr_clr = 1'b0;
        b8.start = 1'b0; b8.cont = 1'b0; b8.result_ready = 1'b0; b8.ovr_clr = 1'b0;

        // Reset state
        tick_n(2);
        check("rst_sample", 32'(b4.sample), 32'd0);
        check("rst_busy", 32'(b4.busy), 32'd0);
        check("rst_valid", 32'(b4.result_valid), 32'd0);
        check("rst_overrun", 32'(b4.overrun), 32'd0);
        check("rst_dac", 32'(b4.dac_code), 32'd0);
        check("rst_result", 32'(b4.result), 32'd0);
        check("rst8_busy", 32'(b8.busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // Table-driven single-shot conversions
        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // Continuous mode, no consumer: second completion overruns
        vin4 = 4'd5; b4.cont = 1'b1; b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        tick_n(5);
        check("c1_result", 32'(b4.result), 32'd5);
        check("c1_valid", 32'(b4.result_valid), 32'd1);
        check("c1_overrun", 32'(b4.overrun), 32'd0);
        check("c1_resample", 32'(b4.sample), 32'd1);
        tick_n(5);
        check("c2_overrun", 32'(b4.overrun), 32'd1);
        check("c2_valid", 32'(b4.result_valid), 32'd1);
        check("c2_result", 32'(b4.result), 32'd5);
        b4.ovr_clr = 1'b1; b4.cont = 1'b0;
        tick();
        check("ovr_cleared", 32'(b4.overrun), 32'd0);
        b4.ovr_clr = 1'b0;
        tick_n(3);
        b4.ovr_clr = 1'b1;
        tick();
        check("ovr_set_wins", 32'(b4.overrun), 32'd1);
        check("c3_valid", 32'(b4.result_valid), 32'd1);
        check("c3_busy0", 32'(b4.busy), 32'd0);
        b4.ovr_clr = 1'b0;
        tick();
        check("cont_off_idle", 32'(b4.busy), 32'd0);
        check("cont_off_nosample", 32'(b4.sample), 32'd0);
        b4.result_ready = 1'b1;
        tick();
        check("c3_consumed", 32'(b4.result_valid), 32'd0);
        b4.result_ready = 1'b0; b4.ovr_clr = 1'b1;
        tick();
        check("ovr_clr2", 32'(b4.overrun), 32'd0);
        b4.ovr_clr = 1'b0;

        // Continuous mode with ready held: back-to-back results every 5 cycles
        vin4 = 4'd11; b4.cont = 1'b1; b4.result_ready = 1'b1; b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        tick_n(5);
        check("b1_valid", 32'(b4.result_valid), 32'd1);
        check("b1_result", 32'(b4.result), 32'd11);
        vin4 = 4'd6;
        tick();
        check("b1_taken", 32'(b4.result_valid), 32'd0);
        tick_n(3);
        check("b2_not_yet", 32'(b4.result_valid), 32'd0);
        tick();
        check("b2_valid", 32'(b4.result_valid), 32'd1);
        check("b2_result", 32'(b4.result), 32'd6);
        check("b2_overrun", 32'(b4.overrun), 32'd0);
        vin4 = 4'd13;
        tick();
        b4.cont = 1'b0;
        tick_n(4);
        check("b3_result", 32'(b4.result), 32'd13);
        check("b3_valid", 32'(b4.result_valid), 32'd1);
        check("b3_busy0", 32'(b4.busy), 32'd0);
        tick();
        check("b_end_idle", 32'(b4.busy), 32'd0);
        check("b_end_valid", 32'(b4.result_valid), 32'd0);
        check("b_end_overrun", 32'(b4.overrun), 32'd0);
        b4.result_ready = 1'b0;

        // start during a conversion is ignored and not queued
        vin4 = 4'd9; b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        tick();
        b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        check("ign_dac", 32'(b4.dac_code), 32'd12);
        check("ign_sample", 32'(b4.sample), 32'd0);
        tick_n(3);
        check("ign_result", 32'(b4.result), 32'd9);
        tick();
        check("ign_no_restart", 32'(b4.busy), 32'd0);
        b4.result_ready = 1'b1;
        tick();
        b4.result_ready = 1'b0;

        // Reset during the third trial aborts the conversion
        vin4 = 4'd11; b4.start = 1'b1;
        tick();
        b4.start = 1'b0;
        tick_n(3);
        check("pre_rst_dac", 32'(b4.dac_code), 32'd10);
        rst_n = 1'b0;
        tick();
        check("abort_busy", 32'(b4.busy), 32'd0);
        check("abort_dac", 32'(b4.dac_code), 32'd0);
        check("abort_result", 32'(b4.result), 32'd0);
        check("abort_valid", 32'(b4.result_valid), 32'd0);
        check("abort_sample", 32'(b4.sample), 32'd0);
        rst_n = 1'b1;
        tick_n(2);
        check("abort_stays_idle", 32'(b4.busy), 32'd0);

        // 8-bit, 3 sample cycles, inverted comparator
        vin8 = 8'hA5; b8.start = 1'b1;
        tick();
        b8.start = 1'b0;
        tick_n(2);
        check("w8_sample_hi", 32'(b8.sample), 32'd1);
        tick();
        check("w8_sample_lo", 32'(b8.sample), 32'd0);
        check("w8_first_trial", 32'(b8.dac_code), 32'h80);
        tick_n(7);
        check("w8_valid_lo", 32'(b8.result_valid), 32'd0);
        tick();
        check("w8_valid_hi", 32'(b8.result_valid), 32'd1);
        check("w8_result", 32'(b8.result), 32'hA5);
        check("w8_dac0", 32'(b8.dac_code), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
